// File: rtl/data_sram_responder.sv
// Responder end of the data_sram req/addr_ok/data_ok interface: an in-order request queue
// with a minimum response latency, backed by a word-addressed RAM.
module data_sram_responder #(
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2,
  parameter int MEM_AW      = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        addr_stall,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int         QMAX     = 4;
  localparam logic [7:0] AGE_MAX  = 8'(LATENCY);
  localparam logic [7:0] AGE_DONE = 8'(LATENCY - 1);
  localparam logic [2:0] CNT_MAX  = 3'(OUTSTANDING);
  localparam logic [1:0] PTR_LAST = 2'(OUTSTANDING - 1);

  function automatic logic [7:0] f_age_inc(input logic [7:0] age);
    return (age >= AGE_MAX) ? AGE_MAX : age + 8'd1;
  endfunction

  function automatic logic [1:0] f_ptr_inc(input logic [1:0] ptr);
    return (ptr == PTR_LAST) ? 2'd0 : ptr + 2'd1;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  function automatic logic [3:0] f_size_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  logic [31:0]       r_mem [2**MEM_AW];
  logic              r_q_wr    [QMAX];
  logic [MEM_AW-1:0] r_q_idx   [QMAX];
  logic [3:0]        r_q_strb  [QMAX];
  logic [31:0]       r_q_wdata [QMAX];
  logic [7:0]        r_q_age   [QMAX];

  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_count;
  logic        r_data_ok;
  logic [31:0] r_rdata;

  logic              w_push;
  logic              w_pop;
  logic              w_aligned;
  logic [MEM_AW-1:0] w_idx;
  logic              w_unused;

  // Fullness uses the registered count only: a pop this cycle does not open a slot this cycle.
  assign data_sram_addr_ok = data_sram_req && !addr_stall && (r_count < CNT_MAX);
  assign w_push            = data_sram_req && data_sram_addr_ok;
  assign w_pop             = (r_count != 3'd0) && (r_q_age[r_rd_ptr] >= AGE_DONE);
  assign w_idx             = data_sram_addr[MEM_AW+1:2];
  assign w_unused          = ^{data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0], data_sram_size};

  assign data_sram_data_ok = r_data_ok;
  assign data_sram_rdata   = r_rdata;

  // Control: pointers, occupancy and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= 2'd0;
      r_wr_ptr  <= 2'd0;
      r_count   <= 3'd0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      r_count   <= r_count + 3'(w_push) - 3'(w_pop);
      r_data_ok <= w_pop;
      r_rdata   <= (w_pop && !r_q_wr[r_rd_ptr]) ? r_mem[r_q_idx[r_rd_ptr]] : 32'd0;
    end
  end

  // Data: queue payload, per-entry age and RAM writes at store completion.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QMAX; i++)
      r_q_age[i] <= f_age_inc(r_q_age[i]);
    if (w_push) begin
      r_q_wr[r_wr_ptr]    <= data_sram_wr;
      r_q_idx[r_wr_ptr]   <= w_idx;
      r_q_strb[r_wr_ptr]  <= data_sram_wstrb;
      r_q_wdata[r_wr_ptr] <= data_sram_wdata;
      r_q_age[r_wr_ptr]   <= 8'd1;
    end
    // A store completing in the reset cycle is dropped along with its response.
    if (w_pop && !rst && r_q_wr[r_rd_ptr])
      r_mem[r_q_idx[r_rd_ptr]] <= f_merge(r_mem[r_q_idx[r_rd_ptr]], r_q_wdata[r_rd_ptr],
                                          r_q_strb[r_rd_ptr]);
  end

  assign w_aligned = (data_sram_size == 2'd0) ||
                     (data_sram_size == 2'd1 && !data_sram_addr[0]) ||
                     (data_sram_size == 2'd2 && data_sram_addr[1:0] == 2'b00);

  a_store_strb: assert property (@(posedge clk) disable iff (rst)
    (w_push && data_sram_wr && w_aligned) |->
      (data_sram_wstrb == 4'h0 ||
       data_sram_wstrb == f_size_strb(data_sram_size, data_sram_addr[1:0])));

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table, hand-written timing sequences,
// and randomized traffic against an in-order response/memory reference model.
module tb_data_sram_responder;
  localparam int LAT  = 3;
  localparam int OUTS = 2;
  localparam int AW   = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.LATENCY(LAT), .OUTSTANDING(OUTS), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .addr_stall(stall),
    .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          dok;
    logic [31:0] rd;
  } rsp_t;

  vec_t        tbl[12];
  rsp_t        mq[$];
  logic [31:0] mmem[8];
  int          k;
  int          last_dok;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic idle();
    req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
    addr = 32'd0; wdata = 32'd0; stall = 1'b0;
  endtask

  // Single isolated transaction: accepted in the issue cycle, response LAT cycles later.
  task automatic do_txn(input vec_t v);
    int got;
    req = 1'b1; wr = v.wr; size = v.size; addr = v.addr; wdata = v.wdata; wstrb = v.strb;
    @(negedge clk);
    chk({v.name, "_aok"}, 32'(addr_ok), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (data_ok) begin
        got = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk({v.name, "_lat"}, 32'(got), 32'(LAT));
    chk({v.name, "_rdata"}, rdata, v.exp);
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle(input bit allow);
    int          w;
    int          lane;
    int          cnt;
    bit          exp_aok;
    bit          exp_dok;
    rsp_t        r;
    req   = allow && ($urandom_range(3) != 0);
    stall = ($urandom_range(4) == 0);
    wr    = 1'($urandom_range(1));
    size  = 2'($urandom_range(2));
    w     = $urandom_range(7);
    case (size)
      2'd0:    lane = $urandom_range(3);
      2'd1:    lane = 2 * $urandom_range(1);
      default: lane = 0;
    endcase
    if (!wr)             wstrb = 4'h0;
    else if (size == 0)  wstrb = 4'b0001 << lane;
    else if (size == 1)  wstrb = 4'b0011 << lane;
    else                 wstrb = 4'hF;
    if (wr && $urandom_range(7) == 0) wstrb = 4'h0;
    addr  = {16'($urandom), 14'(32'h200 + w), 2'(lane)};
    wdata = $urandom;
    @(negedge clk);
    exp_dok = (mq.size() > 0) && (mq[0].dok == k);
    chk("rnd_dok", 32'(data_ok), 32'(exp_dok));
    if (exp_dok) begin
      chk("rnd_rdata", rdata, mq[0].rd);
      void'(mq.pop_front());
    end
    cnt     = mq.size();
    exp_aok = req && !stall && (cnt < OUTS);
    chk("rnd_aok", 32'(addr_ok), 32'(exp_aok));
    if (exp_aok) begin
      r.dok    = (k + LAT > last_dok + 1) ? k + LAT : last_dok + 1;
      last_dok = r.dok;
      if (wr) begin
        mmem[w] = merge(mmem[w], wdata, wstrb);
        r.rd    = 32'd0;
      end else begin
        r.rd = mmem[w];
      end
      mq.push_back(r);
    end
    @(posedge clk); #1;
    k++;
  endtask

  initial begin
    logic [9:0] exp_aok_bits;
    logic [9:0] exp_dok_bits;
    int         acc;
    vec_t       v;

    tbl[0]  = '{"st_word",  1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0};
    tbl[1]  = '{"ld_word",  1'b0, 2'd2, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF};
    tbl[2]  = '{"st_byte",  1'b1, 2'd0, 32'h0000_0100, 32'h5A5A_5A5A, 4'h1, 32'h0};
    tbl[3]  = '{"ld_byte",  1'b0, 2'd2, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BE5A};
    tbl[4]  = '{"st_half",  1'b1, 2'd1, 32'h0000_0102, 32'h1234_1234, 4'hC, 32'h0};
    tbl[5]  = '{"ld_half",  1'b0, 2'd2, 32'h0000_0100, 32'h0,         4'h0, 32'h1234_BE5A};
    tbl[6]  = '{"st_alias", 1'b1, 2'd2, 32'h0001_0104, 32'hCAFE_F00D, 4'hF, 32'h0};
    tbl[7]  = '{"ld_alias", 1'b0, 2'd2, 32'h0000_0104, 32'h0,         4'h0, 32'hCAFE_F00D};
    tbl[8]  = '{"st_nostb", 1'b1, 2'd2, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 32'h0};
    tbl[9]  = '{"ld_nostb", 1'b0, 2'd2, 32'h0001_0104, 32'h0,         4'h0, 32'hCAFE_F00D};
    tbl[10] = '{"st_hiadr", 1'b1, 2'd2, 32'hFFFF_0100, 32'h1122_3344, 4'hF, 32'h0};
    tbl[11] = '{"ld_hiadr", 1'b0, 2'd2, 32'h0000_0100, 32'h0,         4'h0, 32'h1122_3344};

    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_aok", 32'(addr_ok), 32'd0);
    chk("rst_dok", 32'(data_ok), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_dok", 32'(data_ok), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) do_txn(tbl[i]);

    // Back-to-back loads with req held: the third waits for the first response to free a slot.
    exp_aok_bits = 10'b00_0000_1011;
    exp_dok_bits = 10'b00_0101_1000;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req = (acc < 3); wr = 1'b0; size = 2'd2; addr = 32'h100; wstrb = 4'h0;
      @(negedge clk);
      chk("b2b_aok", 32'(addr_ok), 32'(exp_aok_bits[i]));
      chk("b2b_dok", 32'(data_ok), 32'(exp_dok_bits[i]));
      if (data_ok) chk("b2b_rdata", rdata, 32'h1122_3344);
      if (addr_ok) acc++;
      @(posedge clk); #1;
    end
    idle();

    // Backpressure: no acceptance while stalled, accepted the cycle stall drops.
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h104; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_aok", 32'(addr_ok), 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    v = '{"stall_rel", 1'b0, 2'd2, 32'h0000_0104, 32'h0, 4'h0, 32'hCAFE_F00D};
    do_txn(v);

    // Reset with two loads pending: their responses never appear.
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h100;
    @(negedge clk); chk("flush_aok0", 32'(addr_ok), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("flush_aok1", 32'(addr_ok), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(negedge clk); chk("flush_dok_rst", 32'(data_ok), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b1; addr = 32'h104;
    @(negedge clk);
    chk("flush_aok_after", 32'(addr_ok), 32'd1);
    chk("flush_dok3", 32'(data_ok), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("flush_dok", 32'(data_ok), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("flush_new_dok", 32'(data_ok), 32'd1);
    chk("flush_new_rdata", rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    idle();

    // Random traffic over eight words, seeded with known contents.
    for (int w = 0; w < 8; w++) begin
      mmem[w] = $urandom;
      v = '{"seed", 1'b1, 2'd2, 32'h800 + 32'(w) * 4, mmem[w], 4'hF, 32'h0};
      do_txn(v);
    end
    k = 0;
    last_dok = -100;
    for (int i = 0; i < 600; i++) rand_cycle(1'b1);
    for (int i = 0; i < 30; i++) rand_cycle(1'b0);
    chk("drain_empty", 32'(mq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
